// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencer: stage enables/flushes, PC enable, gated D-cache request, halt drain.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dREN_EX_MEM,
  input  logic        dWEN_EX_MEM,
  input  logic        halt_EX_MEM,
  input  logic        pc_src_EX_MEM,
  input  logic        dREN_ID_EX,
  input  logic [4:0]  Rt_ID_EX,
  input  logic [4:0]  Rs_IF_ID,
  input  logic [4:0]  Rt_IF_ID,
  output logic        pc_enable,
  output logic        enable_IF_ID,
  output logic        enable_ID_EX,
  output logic        enable_EX_MEM,
  output logic        enable_MEM_WB,
  output logic        flush_IF_ID,
  output logic        flush_ID_EX,
  output logic        flush_EX_MEM,
  output logic        flush_MEM_WB,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic        halt,
  output logic        mem_timeout
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
  output logic [31:0] loaduse_events
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
  localparam bit               TIMEOUT_EN  = (MEM_TIMEOUT != 0);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             halt_r;
  logic             mem_timeout_r;
  logic             mem_req_s;
  logic             mem_stall_s;
  logic             load_use_s;
  logic             active_s;
  logic             branch_hit_s;
  logic             loaduse_hit_s;

  assign mem_req_s   = dREN_EX_MEM | dWEN_EX_MEM;
  assign mem_stall_s = mem_req_s & ~dhit;
  assign load_use_s  = dREN_ID_EX & (Rt_ID_EX != 5'd0) &
                       ((Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID));
  assign active_s    = (state_r == RUN) | (state_r == MEM_WAIT);
  assign halt        = halt_r;
  assign mem_timeout = mem_timeout_r;

  // Hazard priority resolution and next-state selection.
  always_comb begin
    pc_enable     = 1'b1;
    enable_IF_ID  = 1'b1;
    enable_ID_EX  = 1'b1;
    enable_EX_MEM = 1'b1;
    enable_MEM_WB = 1'b1;
    flush_IF_ID   = 1'b0;
    flush_ID_EX   = 1'b0;
    flush_EX_MEM  = 1'b0;
    flush_MEM_WB  = 1'b0;
    dmemREN       = 1'b0;
    dmemWEN       = 1'b0;
    branch_hit_s  = 1'b0;
    loaduse_hit_s = 1'b0;
    state_next_s  = state_r;
    case (state_r)
      RUN, MEM_WAIT: begin
        dmemREN      = dREN_EX_MEM;
        dmemWEN      = dWEN_EX_MEM;
        state_next_s = RUN;
        if (mem_stall_s) begin
          pc_enable     = 1'b0;
          enable_IF_ID  = 1'b0;
          enable_ID_EX  = 1'b0;
          enable_EX_MEM = 1'b0;
          enable_MEM_WB = 1'b0;
          state_next_s  = MEM_WAIT;
        end else if (halt_EX_MEM) begin
          pc_enable     = 1'b0;
          enable_IF_ID  = 1'b0;
          enable_ID_EX  = 1'b0;
          enable_EX_MEM = 1'b0;
          state_next_s  = DRAIN;
        end else if (pc_src_EX_MEM) begin
          // Wrong-path instructions are squashed, so pending ID/IF stalls are moot.
          flush_IF_ID  = 1'b1;
          flush_ID_EX  = 1'b1;
          flush_EX_MEM = 1'b1;
          branch_hit_s = 1'b1;
        end else if (load_use_s) begin
          pc_enable     = 1'b0;
          enable_IF_ID  = 1'b0;
          flush_ID_EX   = 1'b1;
          loaduse_hit_s = 1'b1;
        end else if (!ihit) begin
          pc_enable   = 1'b0;
          flush_IF_ID = 1'b1;
        end else begin
          pc_enable = 1'b1;
        end
      end
      DRAIN: begin
        pc_enable     = 1'b0;
        enable_IF_ID  = 1'b0;
        enable_ID_EX  = 1'b0;
        enable_EX_MEM = 1'b0;
        state_next_s  = HALTED;
      end
      HALTED: begin
        pc_enable     = 1'b0;
        enable_IF_ID  = 1'b0;
        enable_ID_EX  = 1'b0;
        enable_EX_MEM = 1'b0;
        enable_MEM_WB = 1'b0;
        state_next_s  = HALTED;
      end
      default: begin
        pc_enable     = 1'b0;
        enable_IF_ID  = 1'b0;
        enable_ID_EX  = 1'b0;
        enable_EX_MEM = 1'b0;
        enable_MEM_WB = 1'b0;
        state_next_s  = RUN;
      end
    endcase
  end

  // State, MEM_WAIT counter and sticky status flags.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r       <= RUN;
      cnt_r         <= {CNT_W{1'b0}};
      halt_r        <= 1'b0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      // Counter only survives while staying in MEM_WAIT; any entry or exit restarts it.
      if ((state_r == MEM_WAIT) && (state_next_s == MEM_WAIT)) begin
        cnt_r <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
      if (TIMEOUT_EN && (state_r == MEM_WAIT) && (cnt_r == TIMEOUT_CNT)) begin
        mem_timeout_r <= 1'b1;
      end
      if (state_r == DRAIN) begin
        halt_r <= 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Performance counters; naturally frozen once the sequencer leaves RUN/MEM_WAIT.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cycles   <= 32'd0;
      flush_events   <= 32'd0;
      loaduse_events <= 32'd0;
    end else begin
      if (active_s && !pc_enable) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (branch_hit_s) begin
        flush_events <= flush_events + 32'd1;
      end
      if (loaduse_hit_s) begin
        loaduse_events <= loaduse_events + 32'd1;
      end
    end
  end
`else
  logic unused_perf_s;
  assign unused_perf_s = active_s ^ branch_hit_s ^ loaduse_hit_s;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the five-stage pipeline. Generates the enable and flush for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the PC enable. Inputs are instruction/data memory handshakes, load-use hazards, taken branches/jumps and halt. Owns the gated data-memory request to the cache, tracks outstanding data accesses, and drains the pipeline on halt.

Parameters:
MEM_TIMEOUT, 255, cycles in MEM_WAIT before mem_timeout is set (0 disables the check)
CNT_W, 8, width of the MEM_WAIT cycle counter

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  synchronous active-low reset
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
dREN_EX_MEM  in  1  load in MEM stage
dWEN_EX_MEM  in  1  store in MEM stage
halt_EX_MEM  in  1  halt instruction in MEM stage
pc_src_EX_MEM  in  1  branch taken or jump resolved in MEM stage
dREN_ID_EX  in  1  load in EX stage
Rt_ID_EX  in  5  load destination in EX stage
Rs_IF_ID, Rt_IF_ID  in  5 each  source registers in ID stage
pc_enable  out  1  PC update
enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB  out  1 each  register load
flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  out  1 each  synchronous bubble insert
dmemREN, dmemWEN  out  1 each  gated data request to cache
halt  out  1  sticky: pipeline drained
mem_timeout  out  1  sticky: MEM_WAIT exceeded MEM_TIMEOUT

Behaviour:
- Interface: single clock CLK; nRST is synchronous and active-low.
- States: RUN, MEM_WAIT, DRAIN, HALTED. State register and counter update on the CLK rising edge.
- On nRST=0 at an edge:
  - state←RUN, counter←0, halt←0, mem_timeout←0.
  - Outputs are combinational. Reset does not force them; they follow the rules below from state RUN.
  - Reset applied mid-MEM_WAIT or mid-DRAIN abandons the access or drain; the cache must tolerate the dropped request.
- mem_req = dREN_EX_MEM | dWEN_EX_MEM.
- dmemREN/dmemWEN = dREN_EX_MEM/dWEN_EX_MEM while state ∈ {RUN, MEM_WAIT}; 0 in DRAIN and HALTED.
- In RUN and MEM_WAIT, the following priority applies (first match wins; defaults are all enables=1, all flushes=0, pc_enable=1):
  1. Data stall (mem_req & !dhit): all enables=0, pc_enable=0. RUN→MEM_WAIT; MEM_WAIT stays.
  2. Halt (halt_EX_MEM & !mem_stall): pc_enable=0, enable_IF_ID=enable_ID_EX=enable_EX_MEM=0, enable_MEM_WB=1. →DRAIN.
  3. Taken branch/jump (pc_src_EX_MEM): flush_IF_ID=flush_ID_EX=flush_EX_MEM=1, pc_enable=1. The taken branch/jump overrides the load-use stall and the fetch stall.
  4. Load-use (dREN_ID_EX & Rt_ID_EX≠0 & (Rt_ID_EX==Rs_IF_ID | Rt_ID_EX==Rt_IF_ID)): pc_enable=0, enable_IF_ID=0, flush_ID_EX=1.
  5. Fetch stall (!ihit): pc_enable=0, flush_IF_ID=1. Downstream registers advance.
- A flush takes precedence over the enable on the same register.
- MEM_WAIT→RUN in the cycle dhit=1. The outputs in that cycle follow the rules above with mem_stall=0, so the pipeline advances that cycle.
- Counter (MEM_WAIT only):
  - Increments each cycle in MEM_WAIT and saturates at 2^CNT_W−1.
  - Clears on entry to MEM_WAIT and on exit from it.
  - When counter==MEM_TIMEOUT and MEM_TIMEOUT≠0, mem_timeout←1 (sticky until reset).
- DRAIN (exactly one cycle): all enables=0 except enable_MEM_WB=1, so the halt reaches WB. →HALTED.
- HALTED: all enables=0, pc_enable=0, halt=1. The state is stuck until reset and ignores ihit/dhit.
- Simultaneous events:
  - dhit with ihit=0: data completes; the fetch-stall rule applies.
  - halt_EX_MEM with mem_req pending: the data stall wins; the halt is taken after dhit.

Optional Feature:
PIPE_PERF_CNT_EN:
- Adds outputs stall_cycles[31:0], flush_events[31:0] and loaduse_events[31:0].
- stall_cycles counts cycles with pc_enable=0 in RUN or MEM_WAIT. flush_events counts cycles matching rule 3. loaduse_events counts cycles matching rule 4.
- All three wrap at 2^32, clear on reset, and freeze in HALTED.
- Without the macro: no such ports or logic.

Test Plan:
- Load-use: ID_EX load with Rt_ID_EX=5, Rs_IF_ID=5, ihit=1 → one cycle with pc_enable=0, enable_IF_ID=0, flush_ID_EX=1. With Rt_ID_EX=0 → no stall.
- Data stall: dREN_EX_MEM=1, dhit low for 3 cycles then high → all enables 0 for 3 cycles, state MEM_WAIT, dmemREN=1 throughout. 4th cycle: all enables=1, state RUN.
- Branch plus load-use in the same cycle: pc_src_EX_MEM=1 with a matching load-use → flush_IF_ID/ID_EX/EX_MEM=1, pc_enable=1, no stall.
- Halt: halt_EX_MEM=1, mem_req=0 → DRAIN for 1 cycle with only enable_MEM_WB=1, then halt=1 and all outputs 0. The state persists with ihit toggling and clears after nRST=0 at one edge.
- Timeout: MEM_TIMEOUT=4, dhit held 0 → mem_timeout rises once counter==4 and stays 1 after dhit returns.
- Reset mid-wait: nRST=0 for one edge during MEM_WAIT → next cycle state RUN, counter 0, dmemREN follows dREN_EX_MEM.
